// File: rtl/hex3_digit_source_if.sv
// Control and status bundle for one seven-segment digit source.
// The controller drives mode and load inputs and observes digit, carry and key state.
interface hex3_digit_source_if;
  logic       run;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] digit;
  logic       carry;
  logic       key_held;

  modport master (
    output run,
    output up_dn,
    output load,
    output load_val,
    input  digit,
    input  carry,
    input  key_held
  );

  modport slave (
    input  run,
    input  up_dn,
    input  load,
    input  load_val,
    output digit,
    output carry,
    output key_held
  );
endinterface

// File: rtl/hex3_digit_source.sv
// Digit source for HEX3: advances on a prescaled tick or a debounced key press.
// Supports up/down counting, clamped parallel load, and a carry pulse on wrap.
module hex3_digit_source #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_VAL         = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  hex3_digit_source_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [3:0]    MAXV    = 4'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } db_state_t;

  logic [1:0]    sync;
  logic          k;
  db_state_t     state;
  db_state_t     state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          step;
  logic [PW-1:0] presc;
  logic          tick;
  logic          adv;
  logic [3:0]    digit;
  logic [3:0]    digit_nx;
  logic          carry;
  logic          carry_nx;
  logic [3:0]    clamp_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], key_n};
    end
  end

  assign k = ~sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Acceptance fires on the DEBOUNCE_CYCLES-th consecutive stable cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    step     = 1'b0;
    unique case (state)
      IDLE: begin
        if (k) begin
          state_nx = PRESS_CHK;
          cnt_nx   = '0;
        end
      end
      PRESS_CHK: begin
        if (!k) begin
          state_nx = IDLE;
        end else if (cnt == CNT_TOP) begin
          state_nx = HELD;
          step     = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!k) begin
          state_nx = REL_CHK;
          cnt_nx   = '0;
        end
      end
      REL_CHK: begin
        if (k) begin
          state_nx = HELD;
        end else if (cnt == CNT_TOP) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.key_held = (state == HELD) || (state == REL_CHK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!bus.run || bus.load) begin
      presc <= '0;
    end else if (presc == PRE_TOP) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick = (presc == PRE_TOP);
  assign adv  = bus.run ? tick : step;

  assign clamp_val = (bus.load_val > MAXV) ? MAXV : bus.load_val;

  always_comb begin
    digit_nx = digit;
    carry_nx = 1'b0;
    if (bus.load) begin
      digit_nx = clamp_val;
    end else if (adv && bus.up_dn) begin
      unique case (1'b1)
        (digit == MAXV): begin
          digit_nx = 4'd0;
          carry_nx = 1'b1;
        end
        (digit > MAXV): digit_nx = 4'd0;
        default:        digit_nx = digit + 4'd1;
      endcase
    end else if (adv) begin
      unique case (1'b1)
        (digit == 4'd0): begin
          digit_nx = MAXV;
          carry_nx = 1'b1;
        end
        (digit > MAXV): digit_nx = 4'd0;
        default:        digit_nx = digit - 4'd1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
      carry <= 1'b0;
    end else begin
      digit <= digit_nx;
      carry <= carry_nx;
    end
  end

  assign bus.digit = digit;
  assign bus.carry = carry;

endmodule

// File: tb/tb_hex3_digit_source.sv
// Bench for hex3_digit_source: directed plan then random traffic,
// compared each cycle against a streak/modulo behavioural model.
module tb_hex3_digit_source;
  localparam int TD = 4;
  localparam int DC = 3;
  localparam int MV = 9;

  logic clk = 1'b0;
  logic rst_n;
  logic key_n;

  hex3_digit_source_if bus ();

  hex3_digit_source #(
    .TICK_DIV        (TD),
    .DEBOUNCE_CYCLES (DC),
    .MAX_VAL         (MV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int m_digit;
  bit m_carry;
  bit m_held;
  int m_streak;
  int m_run_len;
  bit m_s1;
  bit m_s2;

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic reset_model();
    m_digit   = 0;
    m_carry   = 0;
    m_held    = 0;
    m_streak  = 0;
    m_run_len = 0;
    m_s1      = 1;
    m_s2      = 1;
  endtask

  // Key is accepted once k differs from the accepted level for DC cycles.
  task automatic model_edge();
    bit k;
    bit step;
    bit tick;
    bit adv;
    if (!rst_n) begin
      reset_model();
      return;
    end
    k    = !m_s2;
    step = 0;
    if (k != m_held) begin
      if (m_streak + 1 >= DC) begin
        step     = !m_held;
        m_held   = k;
        m_streak = 0;
      end else begin
        m_streak++;
      end
    end else begin
      m_streak = 0;
    end
    m_s2 = m_s1;
    m_s1 = key_n;
    tick = 0;
    if (!bus.run || bus.load) begin
      m_run_len = 0;
    end else begin
      tick = (m_run_len % TD) == TD - 1;
      m_run_len++;
    end
    adv     = bus.run ? tick : step;
    m_carry = 0;
    if (bus.load) begin
      m_digit = (int'(bus.load_val) > MV) ? MV : int'(bus.load_val);
    end else if (adv && bus.up_dn) begin
      if (m_digit == MV) begin
        m_digit = 0;
        m_carry = 1;
      end else begin
        m_digit = (m_digit > MV) ? 0 : m_digit + 1;
      end
    end else if (adv) begin
      if (m_digit == 0) begin
        m_digit = MV;
        m_carry = 1;
      end else begin
        m_digit = (m_digit > MV) ? 0 : m_digit - 1;
      end
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".digit"}, bus.digit, 4'(m_digit));
    check({tag, ".carry"}, {3'b000, bus.carry}, {3'b000, m_carry});
    check({tag, ".held"}, {3'b000, bus.key_held}, {3'b000, m_held});
  endtask

  task automatic cyc(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic cycles(string tag, int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic press(string tag, int lo, int hi);
    key_n = 1'b0;
    cycles(tag, lo);
    key_n = 1'b1;
    cycles(tag, hi);
  endtask

  initial begin
    int key_left;
    rst_n        = 1'b0;
    key_n        = 1'b1;
    bus.run      = 1'b0;
    bus.up_dn    = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;
    reset_model();
    #2;
    check_all("reset");
    cycles("reset", 2);
    rst_n = 1'b1;

    bus.run   = 1'b1;
    bus.up_dn = 1'b1;
    cycles("run_up", 44);
    cycles("run_up", 2);
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_all("async_rst");
    cyc("async_rst");
    rst_n   = 1'b1;
    bus.run = 1'b0;
    cycles("idle", 3);

    press("step", 10, 8);
    check("step_once", bus.digit, 4'd1);

    press("bounce", 2, 1);
    press("bounce", 2, 6);
    check("bounce_hold", bus.digit, 4'd1);
    press("bounce", 5, 8);
    check("bounce_step", bus.digit, 4'd2);

    bus.load     = 1'b1;
    bus.load_val = 4'd0;
    cyc("load0");
    bus.load  = 1'b0;
    bus.up_dn = 1'b0;
    press("down_wrap", 6, 8);
    check("down_wrap", bus.digit, 4'd9);

    bus.up_dn = 1'b1;
    bus.run   = 1'b1;
    cycles("pre_tick", 3);
    bus.load     = 1'b1;
    bus.load_val = 4'hC;
    cyc("clamp");
    check("clamp", bus.digit, 4'd9);
    bus.load = 1'b0;
    cycles("after_load", 8);

    cycles("run_key", 2);
    press("run_key", 6, 10);

    bus.run  = 1'b0;
    key_left = 0;
    repeat (600) begin
      if (key_left == 0) begin
        key_n    = 1'($urandom);
        key_left = $urandom_range(1, 8);
      end
      key_left--;
      bus.load     = ($urandom_range(0, 19) == 0);
      bus.load_val = 4'($urandom);
      if ($urandom_range(0, 49) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 29) == 0) bus.up_dn = ~bus.up_dn;
      cyc("random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
